// File: rtl/izhikevich_pkg.sv
// Shared types and fixed-point helpers for the Izhikevich neuron cores.
// Saturating arithmetic is done in a wide signed domain and clamped to the target width.
package izhikevich_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int WIDE_W = 128;
    typedef logic signed [WIDE_W-1:0] wide_t;

    // Clamp a wide signed value into the range of a w-bit two's complement number.
    function automatic wide_t sat_clamp(input wide_t x, input int w);
        wide_t hi;
        wide_t lo;
        hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
        lo = -hi - wide_t'(1);
        if (x > hi) begin
            return hi;
        end
        if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

    function automatic wide_t sat_add(input wide_t a, input wide_t b, input int w);
        wide_t sum;
        sum = a + b;
        return sat_clamp(sum, w);
    endfunction

    // Rounded fixed-point encoding of num/den with q fractional bits.
    function automatic longint fx_frac(input longint num, input longint den, input int q);
        return ((num <<< q) + den / 2) / den;
    endfunction

endpackage

// File: rtl/izhikevich_array_if.sv
// Control, constant and result bundle between the current-injection stage and the neuron array.
interface izhikevich_array_if #(
    parameter int N     = 32,
    parameter int M     = 8,
    parameter int REF_W = 4
) ();

    logic                      start;
    logic                      i_we;
    logic [$clog2(M)-1:0]      i_addr;
    logic signed [N-1:0]       i_data;
    logic signed [N-1:0]       v_init;
    logic signed [N-1:0]       w_init;
    logic signed [N-1:0]       v_th;
    logic signed [N-1:0]       dv_step;
    logic signed [N-1:0]       dw_step;
    logic signed [N-1:0]       a;
    logic signed [N-1:0]       b;
    logic signed [N-1:0]       c;
    logic signed [N-1:0]       d;
    logic [REF_W-1:0]          ref_steps;
    logic [$clog2(M)-1:0]      rd_addr;
    logic signed [N-1:0]       rd_voltage;
    logic signed [N-1:0]       rd_w;
    logic                      busy;
    logic                      done;
    logic [M-1:0]              spikes;
    logic [$clog2(M+1)-1:0]    spike_count;

    modport master (
        output start, i_we, i_addr, i_data,
        output v_init, w_init, v_th, dv_step, dw_step, a, b, c, d, ref_steps,
        output rd_addr,
        input  rd_voltage, rd_w, busy, done, spikes, spike_count
    );

    modport slave (
        input  start, i_we, i_addr, i_data,
        input  v_init, w_init, v_th, dv_step, dw_step, a, b, c, d, ref_steps,
        input  rd_addr,
        output rd_voltage, rd_w, busy, done, spikes, spike_count
    );

endinterface

// File: rtl/izhikevich_update.sv
// Combinational single-neuron Izhikevich update: dv/dw datapath, saturating state adds,
// spike detection and refractory handling.
import izhikevich_pkg::*;

// dv = dv_step * (0.04 v^2 + 5 v + 140 - w + i)
module calc_dv #(
    parameter int N = 32,
    parameter int Q = 16
) (
    input  logic signed [N-1:0] v,
    input  logic signed [N-1:0] w,
    input  logic signed [N-1:0] i,
    input  logic signed [N-1:0] dv_step,
    output logic signed [N-1:0] dv
);
    localparam int W2 = 2 * N;
    localparam logic signed [W2-1:0] K004 = W2'(fx_frac(64'sd4, 64'sd100, Q));
    localparam logic signed [W2-1:0] K140 = W2'(fx_frac(64'sd140, 64'sd1, Q));

    logic signed [W2-1:0] v_ext;
    logic signed [W2-1:0] v_prod;
    logic signed [W2-1:0] v_sq;
    logic signed [W2-1:0] quad_prod;
    logic signed [W2-1:0] quad;
    logic signed [W2-1:0] lin;
    logic signed [W2-1:0] rate_wide;
    logic signed [N-1:0]  rate;
    logic signed [W2-1:0] scaled_prod;
    logic signed [W2-1:0] scaled;

    // The rate is clamped to N bits before scaling so the step multiply fits in 2N bits.
    always_comb begin
        v_ext       = W2'(v);
        v_prod      = v_ext * v_ext;
        v_sq        = v_prod >>> Q;
        quad_prod   = v_sq * K004;
        quad        = quad_prod >>> Q;
        lin         = v_ext * W2'(5);
        rate_wide   = quad + lin + K140 - W2'(w) + W2'(i);
        rate        = N'(sat_clamp(wide_t'(rate_wide), N));
        scaled_prod = W2'(rate) * W2'(dv_step);
        scaled      = scaled_prod >>> Q;
        dv          = N'(sat_clamp(wide_t'(scaled), N));
    end
endmodule

// dw = dw_step * a * (b v - w)
module calc_dw #(
    parameter int N = 32,
    parameter int Q = 16
) (
    input  logic signed [N-1:0] v,
    input  logic signed [N-1:0] w,
    input  logic signed [N-1:0] a,
    input  logic signed [N-1:0] b,
    input  logic signed [N-1:0] dw_step,
    output logic signed [N-1:0] dw
);
    localparam int W2 = 2 * N;

    logic signed [W2-1:0] bv_prod;
    logic signed [W2-1:0] bv;
    logic signed [W2-1:0] diff_wide;
    logic signed [N-1:0]  diff;
    logic signed [W2-1:0] ad_prod;
    logic signed [W2-1:0] ad_wide;
    logic signed [N-1:0]  ad;
    logic signed [W2-1:0] scaled_prod;
    logic signed [W2-1:0] scaled;

    always_comb begin
        bv_prod     = W2'(b) * W2'(v);
        bv          = bv_prod >>> Q;
        diff_wide   = bv - W2'(w);
        diff        = N'(sat_clamp(wide_t'(diff_wide), N));
        ad_prod     = W2'(a) * W2'(diff);
        ad_wide     = ad_prod >>> Q;
        ad          = N'(sat_clamp(wide_t'(ad_wide), N));
        scaled_prod = W2'(ad) * W2'(dw_step);
        scaled      = scaled_prod >>> Q;
        dw          = N'(sat_clamp(wide_t'(scaled), N));
    end
endmodule

module izhikevich_update #(
    parameter int N     = 32,
    parameter int Q     = 16,
    parameter int REF_W = 4
) (
    input  logic signed [N-1:0] v,
    input  logic signed [N-1:0] w,
    input  logic [REF_W-1:0]    refr,
    input  logic signed [N-1:0] i,
    input  logic signed [N-1:0] v_th,
    input  logic signed [N-1:0] dv_step,
    input  logic signed [N-1:0] dw_step,
    input  logic signed [N-1:0] a,
    input  logic signed [N-1:0] b,
    input  logic signed [N-1:0] c,
    input  logic signed [N-1:0] d,
    input  logic [REF_W-1:0]    ref_steps,
    output logic signed [N-1:0] v_next,
    output logic signed [N-1:0] w_next,
    output logic [REF_W-1:0]    refr_next,
    output logic                spike
);
    logic signed [N-1:0] dv;
    logic signed [N-1:0] dw;
    logic signed [N-1:0] v_dyn;
    logic signed [N-1:0] w_dyn;
    logic signed [N-1:0] w_jump;

    calc_dv #(.N(N), .Q(Q)) u_calc_dv (
        .v       (v),
        .w       (w),
        .i       (i),
        .dv_step (dv_step),
        .dv      (dv)
    );

    calc_dw #(.N(N), .Q(Q)) u_calc_dw (
        .v       (v),
        .w       (w),
        .a       (a),
        .b       (b),
        .dw_step (dw_step),
        .dw      (dw)
    );

    // Spike takes priority over refractory hold; otherwise integrate both state variables.
    always_comb begin
        v_dyn     = N'(sat_add(wide_t'(v), wide_t'(dv), N));
        w_dyn     = N'(sat_add(wide_t'(w), wide_t'(dw), N));
        w_jump    = N'(sat_add(wide_t'(w), wide_t'(d), N));
        v_next    = v_dyn;
        w_next    = w_dyn;
        refr_next = refr;
        spike     = 1'b0;
        if (v > v_th) begin
            v_next    = c;
            w_next    = w_jump;
            refr_next = ref_steps;
            spike     = 1'b1;
        end else if (refr != '0) begin
            v_next    = c;
            refr_next = refr - REF_W'(1);
        end
    end
endmodule

// File: rtl/izhikevich_array.sv
// Time-multiplexed array of M Izhikevich neurons: one neuron updated per cycle while RUN,
// spikes published as a packed vector with popcount at step completion.
import izhikevich_pkg::*;

module izhikevich_array #(
    parameter int N     = 32,
    parameter int Q     = 16,
    parameter int M     = 8,
    parameter int REF_W = 4
) (
    input logic              clk,
    input logic              rst,
    izhikevich_array_if.slave bus
);
    localparam int AW = $clog2(M);
    localparam int CW = $clog2(M + 1);

    state_t state;
    state_t state_next;

    logic [AW-1:0]       idx;
    logic                last;
    logic                step_start;
    logic                step_end;

    logic signed [N-1:0] v_mem [M];
    logic signed [N-1:0] w_mem [M];
    logic signed [N-1:0] i_mem [M];
    logic [REF_W-1:0]    r_mem [M];

    logic signed [N-1:0] v_next;
    logic signed [N-1:0] w_next;
    logic [REF_W-1:0]    refr_next;
    logic                spike_now;

    logic [M-1:0]        spike_shadow;
    logic [M-1:0]        spikes_final;
    logic [CW-1:0]       count_final;
    logic [M-1:0]        spikes_q;
    logic [CW-1:0]       count_q;
    logic                done_q;
    logic signed [N-1:0] rd_v_q;
    logic signed [N-1:0] rd_w_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Start is only honoured from IDLE, so a start held through the done cycle chains steps.
    always_comb begin
        state_next = state;
        step_start = 1'b0;
        step_end   = 1'b0;
        last       = (idx == AW'(M - 1));
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = RUN;
                    step_start = 1'b1;
                end
            end
            RUN: begin
                if (last) begin
                    state_next = IDLE;
                    step_end   = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= '0;
        end else if (step_start) begin
            idx <= '0;
        end else if (state == RUN) begin
            idx <= idx + AW'(1);
        end
    end

    izhikevich_update #(.N(N), .Q(Q), .REF_W(REF_W)) u_update (
        .v         (v_mem[idx]),
        .w         (w_mem[idx]),
        .refr      (r_mem[idx]),
        .i         (i_mem[idx]),
        .v_th      (bus.v_th),
        .dv_step   (bus.dv_step),
        .dw_step   (bus.dw_step),
        .a         (bus.a),
        .b         (bus.b),
        .c         (bus.c),
        .d         (bus.d),
        .ref_steps (bus.ref_steps),
        .v_next    (v_next),
        .w_next    (w_next),
        .refr_next (refr_next),
        .spike     (spike_now)
    );

    // Current buffer writes are blocked for the whole step so every neuron sees one snapshot.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < M; k++) begin
                v_mem[k] <= bus.v_init;
                w_mem[k] <= bus.w_init;
                r_mem[k] <= '0;
                i_mem[k] <= '0;
            end
        end else begin
            if (state == RUN) begin
                v_mem[idx] <= v_next;
                w_mem[idx] <= w_next;
                r_mem[idx] <= refr_next;
            end
            if (bus.i_we && state == IDLE) begin
                i_mem[bus.i_addr] <= bus.i_data;
            end
        end
    end

    // The final neuron's spike is merged combinationally so the published vector is complete.
    always_comb begin
        spikes_final      = spike_shadow;
        spikes_final[idx] = spike_now;
        count_final       = '0;
        for (int k = 0; k < M; k++) begin
            count_final = count_final + CW'(spikes_final[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            spike_shadow <= '0;
            spikes_q     <= '0;
            count_q      <= '0;
            done_q       <= 1'b0;
        end else begin
            done_q <= step_end;
            if (step_start) begin
                spike_shadow <= '0;
            end else if (state == RUN) begin
                spike_shadow[idx] <= spike_now;
            end
            if (step_end) begin
                spikes_q <= spikes_final;
                count_q  <= count_final;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_v_q <= '0;
            rd_w_q <= '0;
        end else begin
            rd_v_q <= v_mem[bus.rd_addr];
            rd_w_q <= w_mem[bus.rd_addr];
        end
    end

    assign bus.busy        = (state == RUN);
    assign bus.done        = done_q;
    assign bus.spikes      = spikes_q;
    assign bus.spike_count = count_q;
    assign bus.rd_voltage  = rd_v_q;
    assign bus.rd_w        = rd_w_q;

endmodule
